fetch_stage: RTL and testbench



---
 rtl/if_pkg.sv | 18 +
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// The fetch FSM state type is exported so the IF/ID register and benches can reference it.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold on stall, or fall back to a NOP bubble.
// A flush beats both load and stall so a redirect never lets a wrong-path word through.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic        i_stall,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
      r_pc4   <= 32'h0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + 32'd4;
    end else if (!i_stall) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, single-outstanding fetch FSM, kill flag for redirected responses,
// and a one-word skid buffer used when a response lands while the Decoder is stalled.
module fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_kill;
  logic [31:0]  r_skid;

  logic         w_id_valid;
  logic         w_take_rsp;
  logic         w_take_skid;
  logic         w_load;
  logic [31:0]  w_load_instr;

  // A response may go straight into IF/ID only if the slot is free or draining this cycle.
  assign w_take_rsp   = (r_state == WAIT) && imem_rvalid && !r_kill && (!id_stall || !w_id_valid);
  assign w_take_skid  = (r_state == HOLD) && !id_stall;
  assign w_load       = !redirect_valid && (w_take_rsp || w_take_skid);
  assign w_load_instr = (r_state == HOLD) ? r_skid : imem_rdata;

  assign imem_req  = (r_state == FETCH) && !rst;
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_state <= FETCH;
      r_kill  <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= word_align(redirect_pc);
      case (r_state)
        FETCH: begin
          // The old-pc request was accepted this cycle; its response must be dropped.
          if (imem_ready) begin
            r_state <= WAIT;
            r_kill  <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_state <= FETCH;
            r_kill  <= 1'b0;
          end else begin
            r_kill  <= 1'b1;
          end
        end
        default: r_state <= FETCH;
      endcase
    end else begin
      case (r_state)
        FETCH: if (imem_ready) r_state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= FETCH;
            end else if (!id_stall || !w_id_valid) begin
              r_pc    <= r_pc + 32'd4;
              r_state <= FETCH;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == WAIT) && imem_rvalid) r_skid <= imem_rdata;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_load  (w_load),
    .i_stall (id_stall),
    .i_instr (w_load_instr),
    .i_pc    (r_pc),
    .o_valid (w_id_valid),
    .o_instr (id_instr),
    .o_pc    (id_pc),
    .o_pc4   (id_pc4)
  );

  assign id_valid = w_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a transaction-level model predicts every output each cycle,
// and literal expectations at key cycles pin the model to hand-derived values.
module tb_fetch_stage;
  import if_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  int checks   = 0;
  int failures = 0;
  int resp_delay = 0;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_8113;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: answers each accepted request resp_delay cycles after the zero-wait slot.
  initial begin : responder
    logic        n_acc, n_rst, pend;
    logic [31:0] n_addr, p_addr;
    int          cnt;
    pend = 1'b0; cnt = 0; p_addr = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      n_acc  = imem_req && imem_ready;
      n_addr = imem_addr;
      n_rst  = rst;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (n_rst) pend = 1'b0;
      else if (n_acc) begin
        pend = 1'b1; cnt = resp_delay; p_addr = n_addr;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(p_addr);
          pend = 1'b0;
        end else cnt--;
      end
    end
  end

  // Behavioural model: tracks an outstanding request, whether it is dead, a parked word,
  // and what the Decoder should be seeing.
  logic        m_started = 1'b0;
  logic [31:0] m_pc;
  logic        m_busy, m_dead, m_held;
  logic [31:0] m_skid;
  logic        e_valid;
  logic [31:0] e_instr, e_pc, e_pc4;

  initial begin : model
    logic acc, got, loaded;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pc = 32'h0; m_busy = 0; m_dead = 0; m_held = 0;
        e_valid = 0; e_instr = NOP; e_pc = 0; e_pc4 = 0;
      end else begin
        acc = !m_busy && !m_held && imem_ready;
        if (redirect_valid) begin
          m_pc = {redirect_pc[31:2], 2'b00};
          e_valid = 0; e_instr = NOP;
          m_held = 0;
          if (acc) begin
            m_busy = 1; m_dead = 1;
          end else if (m_busy) begin
            if (imem_rvalid) begin m_busy = 0; m_dead = 0; end
            else m_dead = 1;
          end
        end else begin
          got = m_busy && imem_rvalid;
          loaded = 0;
          if (got && m_dead) begin
            m_busy = 0; m_dead = 0;
          end else if (got && (!id_stall || !e_valid)) begin
            e_valid = 1; e_instr = imem_rdata; e_pc = m_pc; e_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4; m_busy = 0; loaded = 1;
          end else if (got) begin
            m_held = 1; m_skid = imem_rdata; m_busy = 0;
          end else if (m_held && !id_stall) begin
            e_valid = 1; e_instr = m_skid; e_pc = m_pc; e_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4; m_held = 0; loaded = 1;
          end
          if (acc) m_busy = 1;
          if (!loaded && !id_stall) begin e_valid = 0; e_instr = NOP; end
        end
      end
      m_started = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("m_imem_req",  {31'b0, imem_req}, {31'b0, (!rst && !m_busy && !m_held)});
        chk("m_imem_addr", imem_addr, m_pc);
        chk("m_id_valid",  {31'b0, id_valid}, {31'b0, e_valid});
        chk("m_id_instr",  id_instr, e_instr);
        chk("m_id_pc",     id_pc, e_pc);
        chk("m_id_pc4",    id_pc4, e_pc4);
        if (imem_rvalid) chk("rvalid_protocol", {31'b0, m_busy}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    rst = 1'b1; imem_ready = 1'b1; id_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, NOP);
    chk("rst_id_pc4",   id_pc4, 32'h0);
    chk("rst_req",      {31'b0, imem_req}, 32'd0);

    // Zero-wait fetches of the first two words
    tick(); rst = 1'b0;
    @(negedge clk); chk("a_req", {31'b0, imem_req}, 32'd1); chk("a_addr", imem_addr, 32'h0);
    tick(); @(negedge clk); chk("b_req", {31'b0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    chk("c_valid", {31'b0, id_valid}, 32'd1); chk("c_instr", id_instr, 32'h0050_0093);
    chk("c_pc", id_pc, 32'h0); chk("c_pc4", id_pc4, 32'h4); chk("c_addr", imem_addr, 32'h4);
    tick(); @(negedge clk); chk("d_valid", {31'b0, id_valid}, 32'd0);

    // Memory not ready for three cycles at pc=8
    tick(); imem_ready = 1'b0;
    @(negedge clk); chk("e_instr", id_instr, 32'h0010_8113); chk("e_pc", id_pc, 32'h4);
    chk("e_addr", imem_addr, 32'h8);
    tick(); @(negedge clk); chk("f_addr", imem_addr, 32'h8); chk("f_req", {31'b0, imem_req}, 32'd1);
    tick(); @(negedge clk); chk("g_addr", imem_addr, 32'h8);
    tick(); imem_ready = 1'b1; @(negedge clk); chk("h_req", {31'b0, imem_req}, 32'd1);
    tick(); @(negedge clk); chk("i_addr_wait", imem_addr, 32'h8);

    // Stall while the pc=12 response arrives -> parked in HOLD
    tick(); id_stall = 1'b1;
    @(negedge clk); chk("j_pc", id_pc, 32'h8); chk("j_addr", imem_addr, 32'hC);
    tick(); @(negedge clk); chk("k_pc", id_pc, 32'h8);
    tick(); @(negedge clk);
    chk("l_state", 32'(dut.r_state), 32'(HOLD)); chk("l_pc", id_pc, 32'h8);
    chk("l_req", {31'b0, imem_req}, 32'd0);
    tick(); id_stall = 1'b0; @(negedge clk); chk("m_state", 32'(dut.r_state), 32'(HOLD));
    tick(); id_stall = 1'b1; resp_delay = 2;
    @(negedge clk); chk("n_pc", id_pc, 32'hC); chk("n_instr", id_instr, mem_word(32'hC));
    chk("n_addr", imem_addr, 32'h10);

    // Redirect while waiting on a slow response
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk); chk("o_valid_held", {31'b0, id_valid}, 32'd1);
    tick(); redirect_valid = 1'b0; id_stall = 1'b0; resp_delay = 0;
    @(negedge clk); chk("p_valid", {31'b0, id_valid}, 32'd0); chk("p_instr", id_instr, NOP);
    chk("p_addr", imem_addr, 32'h100);
    tick(); @(negedge clk); chk("q_req", {31'b0, imem_req}, 32'd0);
    tick(); @(negedge clk); chk("r_req", {31'b0, imem_req}, 32'd1); chk("r_addr", imem_addr, 32'h100);
    tick();

    // Redirect in the same cycle a request is accepted, under stall
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; id_stall = 1'b1;
    @(negedge clk); chk("t_pc", id_pc, 32'h100); chk("t_addr", imem_addr, 32'h104);
    tick(); redirect_valid = 1'b0; id_stall = 1'b0;
    @(negedge clk); chk("u_valid", {31'b0, id_valid}, 32'd0); chk("u_instr", id_instr, NOP);
    chk("u_addr", imem_addr, 32'h200); chk("u_state", 32'(dut.r_state), 32'(WAIT));
    tick(); @(negedge clk); chk("v_addr", imem_addr, 32'h200); chk("v_valid", {31'b0, id_valid}, 32'd0);
    tick();

    // Redirect to the top of the address space (low bits masked), then wrap
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; imem_ready = 1'b0;
    @(negedge clk); chk("x_pc", id_pc, 32'h200); chk("x_instr", id_instr, mem_word(32'h200));
    tick(); redirect_valid = 1'b0; imem_ready = 1'b1;
    @(negedge clk); chk("y_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick(); resp_delay = 3;
    @(negedge clk); chk("aa_pc", id_pc, 32'hFFFF_FFFC); chk("aa_pc4", id_pc4, 32'h0);
    chk("aa_addr", imem_addr, 32'h0);

    // Reset in the middle of a wait
    tick(); rst = 1'b1;
    @(negedge clk); chk("ab_state", 32'(dut.r_state), 32'(WAIT)); chk("ab_req", {31'b0, imem_req}, 32'd0);
    tick(); @(negedge clk);
    chk("ac_valid", {31'b0, id_valid}, 32'd0); chk("ac_instr", id_instr, NOP);
    chk("ac_pc", id_pc, 32'h0); chk("ac_pc4", id_pc4, 32'h0); chk("ac_addr", imem_addr, 32'h0);
    tick(); rst = 1'b0; resp_delay = 0;
    @(negedge clk); chk("ad_req", {31'b0, imem_req}, 32'd1); chk("ad_addr", imem_addr, 32'h0);
    tick(); tick(); @(negedge clk);
    chk("af_instr", id_instr, 32'h0050_0093); chk("af_pc", id_pc, 32'h0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
